cnn_conv_engine: RTL and testbench

Parametrised successor to the fixed 64-pixel `cnn_top` core. It accepts a KxK kernel and an IMG_H x IMG_W image over a valid/ready stream and performs a valid-mode 2-D convolution at one MAC per cycle. Each output position gets optional ReLU, and all positions are reduced by a runtime-selected pooling mode (sum or max) to a single scalar `value` with a `done` pulse. It sits where `cnn_top` sits today: behind the core loader, feeding the per-core result collector.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/cnn_mac_unit.sv | 39 +++
 rtl/cnn_conv_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_cnn_conv_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and sizing helpers for the convolution engine.
// Holds the FSM state encoding and pooling-mode constants.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_IMG,
        CONV,
        ACT,
        FIN
    } state_e;

    localparam logic POOL_SUM = 1'b0;
    localparam logic POOL_MAX = 1'b1;

    // Narrowest accumulator that holds K*K full-precision products
    function automatic int acc_w_min(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k);
    endfunction

endpackage

// File: rtl/cnn_mac_unit.sv
// cnn_mac_unit: signed DATA_W x DATA_W multiply-accumulate into ACC_W,
// with synchronous clear (priority) and accumulate enable.
module cnn_mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    // Full-precision product sign-extended into the accumulator
    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: KxK valid-mode convolution over a streamed image,
// with per-position ReLU and sum/max pooling to one scalar result.
module cnn_conv_engine
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode_max,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     busy,
    output logic signed [ACC_W-1:0]  value,
    output logic                     done
);

    localparam int KK   = K * K;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int OH   = IMG_H - K + 1;
    localparam int OW   = IMG_W - K + 1;
    localparam int W_IW = (KK > 1) ? $clog2(KK) : 1;
    localparam int P_IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int RW   = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW   = (OW > 1) ? $clog2(OW) : 1;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < acc_w_min(DATA_W, K)) begin : g_accw_chk
        $error("cnn_conv_engine: ACC_W too narrow for DATA_W and K");
    end
    if (K < 1 || IMG_W < K || IMG_H < K) begin : g_size_chk
        $error("cnn_conv_engine: need K >= 1 and image at least KxK");
    end

    state_e                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic                      relu_q, relu_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rdy_q, rdy_d;
    logic                      first_q, first_d;
    logic signed [ACC_W-1:0]   value_q, value_d;
    logic signed [ACC_W-1:0]   pool_q, pool_d;
    logic [P_IW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [KW-1:0]             ki_q, ki_d;
    logic [KW-1:0]             kj_q, kj_d;

    logic signed [DATA_W-1:0]  w_q [KK];
    logic signed [DATA_W-1:0]  img_q [NPIX];

    logic                      accept;
    logic                      w_we;
    logic                      img_we;
    logic                      mac_en;
    logic                      mac_clr;
    logic                      last_k;
    logic                      last_pos;
    logic [W_IW-1:0]           w_addr;
    logic [P_IW-1:0]           p_addr;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   act_val;
    logic signed [ACC_W-1:0]   max_val;
    logic signed [ACC_W-1:0]   sat_sum;
    logic [ACC_W:0]            sum_x;

    cnn_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (w_q[w_addr]),
        .b   (img_q[p_addr]),
        .acc (acc)
    );

    // Handshake, buffer addressing and post-MAC ReLU / pooling datapath
    always_comb begin
        accept   = rdy_q && in_valid;
        w_we     = accept && (state_q == LOAD_W);
        img_we   = accept && (state_q == LOAD_IMG);
        mac_en   = (state_q == CONV);
        mac_clr  = (state_q == ACT) || ((state_q == IDLE) && start);
        last_k   = (ki_q == KW'(K - 1)) && (kj_q == KW'(K - 1));
        last_pos = (row_q == RW'(OH - 1)) && (col_q == CW'(OW - 1));
        w_addr   = W_IW'(int'(ki_q) * K + int'(kj_q));
        p_addr   = P_IW'((int'(row_q) + int'(ki_q)) * IMG_W
                         + int'(col_q) + int'(kj_q));
        act_val  = (relu_q && acc[ACC_W-1]) ? '0 : acc;
        max_val  = (first_q || (act_val > pool_q)) ? act_val : pool_q;
        sum_x    = {act_val[ACC_W-1], act_val} + {pool_q[ACC_W-1], pool_q};
        sat_sum  = sum_x[ACC_W-1:0];
        if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
            sat_sum = sum_x[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

    // Sequencer: load weights, load image, scan positions, finish
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        relu_d  = relu_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdy_d   = rdy_q;
        first_d = first_q;
        value_d = value_q;
        pool_d  = pool_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    mode_d  = mode_max;
                    relu_d  = relu_en;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b1;
                    first_d = 1'b1;
                    pool_d  = '0;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (accept) begin
                    if (cnt_q == P_IW'(KK - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_IMG;
                    end else begin
                        cnt_d = cnt_q + P_IW'(1);
                    end
                end
            end
            LOAD_IMG: begin
                if (accept) begin
                    if (cnt_q == P_IW'(NPIX - 1)) begin
                        state_d = CONV;
                        rdy_d   = 1'b0;
                        cnt_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        ki_d    = '0;
                        kj_d    = '0;
                    end else begin
                        cnt_d = cnt_q + P_IW'(1);
                    end
                end
            end
            CONV: begin
                if (last_k) begin
                    ki_d    = '0;
                    kj_d    = '0;
                    state_d = ACT;
                end else if (kj_q == KW'(K - 1)) begin
                    kj_d = '0;
                    ki_d = ki_q + KW'(1);
                end else begin
                    kj_d = kj_q + KW'(1);
                end
            end
            ACT: begin
                pool_d  = (mode_q == POOL_MAX) ? max_val : sat_sum;
                first_d = 1'b0;
                if (last_pos) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    value_d = pool_d;
                end else begin
                    state_d = CONV;
                    if (col_q == CW'(OW - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            relu_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
            first_q <= 1'b0;
            value_q <= '0;
            pool_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ki_q    <= '0;
            kj_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            relu_q  <= relu_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
            first_q <= first_d;
            value_q <= value_d;
            pool_q  <= pool_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ki_q    <= ki_d;
            kj_q    <= kj_d;
        end
    end

    // Weight and image buffers; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_we)   w_q[W_IW'(cnt_q)] <= in_data;
        if (img_we) img_q[cnt_q]      <= in_data;
    end

    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign value    = value_q;

endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb_cnn_conv_engine: table-driven jobs plus gap/poke and abort sequences,
// checked against a behavioural convolution/pooling model.
module tb_cnn_conv_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               mode_max = 1'b0;
    logic               relu_en = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic signed [7:0]  in_data_b;
    logic               in_ready_a, in_ready_b;
    logic               busy_a, busy_b;
    logic               done_a, done_b;
    logic signed [47:0] value_a;
    logic signed [19:0] value_b;

    assign in_data_b = in_data[7:0];

    cnn_conv_engine u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode_max (mode_max),
        .relu_en  (relu_en),
        .in_valid (in_valid),
        .in_ready (in_ready_a),
        .in_data  (in_data),
        .busy     (busy_a),
        .value    (value_a),
        .done     (done_a)
    );

    cnn_conv_engine #(
        .IMG_W  (8),
        .IMG_H  (8),
        .K      (3),
        .DATA_W (8),
        .ACC_W  (20)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode_max (mode_max),
        .relu_en  (relu_en),
        .in_valid (in_valid),
        .in_ready (in_ready_b),
        .in_data  (in_data_b),
        .busy     (busy_b),
        .value    (value_b),
        .done     (done_b)
    );

    typedef struct {
        longint ea;
        longint eb;
    } exp_t;

    typedef struct {
        bit     mx;
        bit     rl;
        int     wp;
        int     wc;
        int     pp;
        int     pc;
        bit     mdl;
        longint ea;
        longint eb;
    } vec_t;

    int     wbuf [9];
    int     pbuf [64];
    exp_t   sb [$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     done_cnt = 0;
    int     cyc = 0;
    int     t_last = 0;
    longint last_a = 0;
    bit     post_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint golden(input bit mx, input bit rl, input int accw);
        longint hi, lo, pool, s;
        bit     first;
        hi    = (longint'(1) <<< (accw - 1)) - 1;
        lo    = -hi - 1;
        pool  = 0;
        first = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += longint'(wbuf[i*3+j]) * longint'(pbuf[(r+i)*8 + c+j]);
                if (rl && s < 0) s = 0;
                if (mx) begin
                    if (first || s > pool) pool = s;
                end else begin
                    pool += s;
                    if (pool > hi) pool = hi;
                    if (pool < lo) pool = lo;
                end
                first = 1'b0;
            end
        end
        return pool;
    endfunction

    task automatic fill(input int wp, input int wc, input int pp, input int pc);
        for (int i = 0; i < 9; i++) begin
            case (wp)
                0:       wbuf[i] = wc;
                1:       wbuf[i] = i - 4;
                default: wbuf[i] = int'($urandom_range(0, 200)) - 100;
            endcase
        end
        for (int i = 0; i < 64; i++) begin
            case (pp)
                0:       pbuf[i] = pc;
                1:       pbuf[i] = ((i * 7) % 23) - 11;
                default: pbuf[i] = int'($urandom_range(0, 200)) - 100;
            endcase
        end
    endtask

    // Completion monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (post_done) begin
            chk("busy_after_done", longint'(busy_a), 0);
            chk("done_width", longint'(done_a), 0);
            post_done = 1'b0;
        end
        if (rst && done_a) begin
            done_cnt++;
            chk("done_b_align", longint'(done_b), 1);
            chk("busy_at_done", longint'(busy_a), 1);
            chk("latency", longint'(cyc - t_last), 361);
            if (sb.size() == 0) begin
                chk("unexpected_done", longint'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("value_a", longint'(value_a), e.ea);
                chk("value_b", longint'(value_b), e.eb);
            end
            last_a    = longint'(value_a);
            post_done = 1'b1;
        end
    end

    task automatic run_job(input bit mx, input bit rl, input bit gaps,
                           input bit poke, input bit abort,
                           input longint ea, input longint eb);
        int n, k, target;
        bit hs;
        n = 0;
        k = 0;
        if (!abort) sb.push_back('{ea, eb});
        target = done_cnt + 1;
        @(posedge clk); #1;
        start    = 1'b1;
        mode_max = mx;
        relu_en  = rl;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < 73 && k < 2000) begin
            k++;
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = (n < 9) ? 16'(wbuf[n]) : 16'(pbuf[n-9]);
            if (poke) begin
                start    = ($urandom_range(0, 3) == 0);
                mode_max = ~mx;
                relu_en  = ~rl;
            end
            @(negedge clk);
            hs = in_valid && in_ready_a;
            if (hs && n == 72) t_last = cyc;
            if (hs) n++;
            @(posedge clk); #1;
        end
        if (n < 73) chk("load_timeout", longint'(n), 73);
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        mode_max = mx;
        relu_en  = rl;
        if (poke) begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (abort) begin
            repeat (50) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("abort_value_a", longint'(value_a), 0);
            chk("abort_value_b", longint'(value_b), 0);
            chk("abort_busy", longint'(busy_a), 0);
            chk("abort_done", longint'(done_a), 0);
            chk("abort_ready", longint'(in_ready_a), 0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            repeat (3) @(negedge clk);
            chk("abort_no_done", longint'(done_cnt), longint'(target - 1));
            chk("abort_idle_busy", longint'(busy_a), 0);
            return;
        end
        k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) chk("done_timeout", longint'(done_cnt), longint'(target));
        repeat (5) @(negedge clk);
        chk("single_done", longint'(done_cnt), longint'(target));
        chk("idle_ready", longint'(in_ready_a), 0);
    endtask

    initial begin
        vec_t   tbl [10];
        longint ea, eb, saved;

        tbl[0] = '{1'b0, 1'b1, 0, 1,   0, 1,    1'b0, 324,      324};
        tbl[1] = '{1'b1, 1'b1, 0, 1,   0, 1,    1'b0, 9,        9};
        tbl[2] = '{1'b0, 1'b0, 0, -1,  0, 1,    1'b0, -324,     -324};
        tbl[3] = '{1'b0, 1'b1, 0, -1,  0, 1,    1'b0, 0,        0};
        tbl[4] = '{1'b0, 1'b0, 0, 127, 0, 127,  1'b0, 5225796,  524287};
        tbl[5] = '{1'b0, 1'b0, 0, 127, 0, -128, 1'b0, -5266944, -524288};
        tbl[6] = '{1'b1, 1'b0, 0, -1,  0, 1,    1'b0, -9,       -9};
        tbl[7] = '{1'b0, 1'b0, 1, 0,   1, 0,    1'b1, 0,        0};
        tbl[8] = '{1'b1, 1'b1, 1, 0,   1, 0,    1'b1, 0,        0};
        tbl[9] = '{1'b0, 1'b1, 2, 0,   2, 0,    1'b1, 0,        0};

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value_a", longint'(value_a), 0);
        chk("rst_value_b", longint'(value_b), 0);
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_done", longint'(done_a), 0);
        chk("rst_ready", longint'(in_ready_a), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready_after_rst", longint'(in_ready_a), 0);

        for (int i = 0; i < 10; i++) begin
            fill(tbl[i].wp, tbl[i].wc, tbl[i].pp, tbl[i].pc);
            ea = tbl[i].ea;
            eb = tbl[i].eb;
            if (tbl[i].mdl) begin
                ea = golden(tbl[i].mx, tbl[i].rl, 48);
                eb = golden(tbl[i].mx, tbl[i].rl, 20);
            end
            run_job(tbl[i].mx, tbl[i].rl, 1'b0, 1'b0, 1'b0, ea, eb);
        end

        fill(2, 0, 2, 0);
        ea = golden(1'b0, 1'b0, 48);
        eb = golden(1'b0, 1'b0, 20);
        run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
        saved = last_a;
        run_job(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ea, eb);
        chk("gap_vs_nogap", last_a, saved);

        fill(1, 0, 1, 0);
        run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        ea = golden(1'b1, 1'b0, 48);
        eb = golden(1'b1, 1'b0, 20);
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
        chk("sb_drained", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
